// File: rtl/tl_cntr_multi_if.sv
// Sensor inputs and lamp/state outputs of the multi-approach traffic-light controller.
interface tl_cntr_multi_if #(
  parameter int unsigned NUM_DIR = 2
);
  localparam int unsigned DW = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;

  logic [NUM_DIR-1:0]   T;
  logic [NUM_DIR-1:0]   TL;
  logic [2*NUM_DIR-1:0] L;
  logic [2*NUM_DIR-1:0] LL;
  logic [DW-1:0]        dir;
  logic [1:0]           phase;

  modport master (
    output T, TL,
    input  L, LL, dir, phase
  );

  modport slave (
    input  T, TL,
    output L, LL, dir, phase
  );
endinterface

// File: rtl/tl_cntr_multi.sv
// Round-robin traffic-light controller, NUM_DIR approaches, straight + protected left phases.
// Define TL_MAX_GREEN_EN to force green exits after MAX_GREEN cycles.
module tl_cntr_multi #(
  parameter int unsigned NUM_DIR       = 2,
  parameter int unsigned MIN_GREEN     = 3,
  parameter int unsigned YELLOW_CYCLES = 2,
  parameter int unsigned MAX_GREEN     = 8
) (
  input logic             clk,
  input logic             reset,
  tl_cntr_multi_if.slave  bus
);

  localparam int unsigned DW      = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;
  localparam int unsigned MAX_A   = (MIN_GREEN > YELLOW_CYCLES) ? MIN_GREEN : YELLOW_CYCLES;
  localparam int unsigned MAX_B   = (MAX_A > MAX_GREEN) ? MAX_A : MAX_GREEN;
  localparam int unsigned CNT_TOP = MAX_B - 1;
  localparam int unsigned CW      = (CNT_TOP > 0) ? $clog2(CNT_TOP + 1) : 1;
  localparam int unsigned LW      = 2 * NUM_DIR;

  typedef enum logic [1:0] {
    StGrn  = 2'b00,
    StYel  = 2'b01,
    StLgrn = 2'b10,
    StLyel = 2'b11
  } phase_e;

  logic [DW-1:0] dir_q, dir_d;
  phase_e        phase_q, phase_d;
  logic [CW-1:0] cnt_q;
  logic [LW-1:0] l_q, l_d, ll_q, ll_d;
  logic          leave, green_done, yel_done, max_hit;

  assign green_done = (cnt_q >= CW'(MIN_GREEN - 1));
  assign yel_done   = (cnt_q == CW'(YELLOW_CYCLES - 1));

`ifdef TL_MAX_GREEN_EN
  assign max_hit = (cnt_q == CW'(MAX_GREEN - 1));
`else
  assign max_hit = 1'b0;
`endif

  always_comb begin
    leave   = 1'b0;
    dir_d   = dir_q;
    phase_d = phase_q;
    unique case (phase_q)
      StGrn: begin
        leave = (green_done && !bus.T[dir_q]) || max_hit;
        if (leave) phase_d = StYel;
      end
      StYel: begin
        leave = yel_done;
        if (leave) phase_d = StLgrn;
      end
      StLgrn: begin
        leave = (green_done && !bus.TL[dir_q]) || max_hit;
        if (leave) phase_d = StLyel;
      end
      StLyel: begin
        leave = yel_done;
        if (leave) begin
          phase_d = StGrn;
          // Explicit wrap so non-power-of-2 NUM_DIR never reaches an unused code.
          dir_d   = (dir_q == DW'(NUM_DIR - 1)) ? '0 : dir_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Lamps are decoded from the next state and registered alongside it.
  always_comb begin
    l_d  = '0;
    ll_d = '0;
    unique case (phase_d)
      StGrn:   l_d[{dir_d, 1'b0} +: 2]  = 2'b01;
      StYel:   l_d[{dir_d, 1'b0} +: 2]  = 2'b10;
      StLgrn:  ll_d[{dir_d, 1'b0} +: 2] = 2'b01;
      StLyel:  ll_d[{dir_d, 1'b0} +: 2] = 2'b10;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q   <= '0;
      phase_q <= StGrn;
      cnt_q   <= '0;
      l_q     <= LW'(2'b01);
      ll_q    <= '0;
    end else begin
      dir_q   <= dir_d;
      phase_q <= phase_d;
      l_q     <= l_d;
      ll_q    <= ll_d;
      if (leave) begin
        cnt_q <= '0;
      end else if (cnt_q != CW'(CNT_TOP)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.dir   = dir_q;
  assign bus.phase = phase_q;
  assign bus.L     = l_q;
  assign bus.LL    = ll_q;

endmodule

// File: tb/tb_tl_cntr_multi.sv
// Scoreboard bench: 4-approach directed sequences plus a 3-approach random invariant run.
module tb_tl_cntr_multi;

  localparam int unsigned ND  = 4;
  localparam int unsigned MG  = 3;
  localparam int unsigned YC  = 2;
  localparam int unsigned MXG = 8;

  localparam logic [1:0] GRN = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] LG  = 2'b10;
  localparam logic [1:0] LY  = 2'b11;

  typedef struct packed {
    logic [1:0] d;
    logic [1:0] ph;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset3 = 1'b1;
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  tl_cntr_multi_if #(.NUM_DIR(ND)) bus4 ();
  tl_cntr_multi_if #(.NUM_DIR(3))  bus3 ();

  tl_cntr_multi #(
    .NUM_DIR(ND), .MIN_GREEN(MG), .YELLOW_CYCLES(YC), .MAX_GREEN(MXG)
  ) u_dut4 (
    .clk(clk), .reset(reset), .bus(bus4)
  );

  tl_cntr_multi #(
    .NUM_DIR(3), .MIN_GREEN(MG), .YELLOW_CYCLES(YC), .MAX_GREEN(MXG)
  ) u_dut3 (
    .clk(clk), .reset(reset3), .bus(bus3)
  );

  function automatic logic [2*ND-1:0] lamp(input logic [1:0] d, input logic [1:0] ph,
                                           input bit left);
    logic [2*ND-1:0] v;
    logic [1:0]      code;
    v = '0;
    if (!left) code = (ph == GRN) ? 2'b01 : (ph == YEL) ? 2'b10 : 2'b00;
    else       code = (ph == LG)  ? 2'b01 : (ph == LY)  ? 2'b10 : 2'b00;
    v[2*d +: 2] = code;
    return v;
  endfunction

  task automatic step(input logic rst, input logic [ND-1:0] t, input logic [ND-1:0] tl,
                      input logic [1:0] d, input logic [1:0] ph);
    exp_t e;
    @(negedge clk);
    reset   = rst;
    bus4.T  = t;
    bus4.TL = tl;
    e.d  = d;
    e.ph = ph;
    exp_q.push_back(e);
  endtask

  task automatic run(input logic [ND-1:0] t, input logic [ND-1:0] tl,
                     input logic [1:0] d, input logic [1:0] ph, input int n);
    repeat (n) step(1'b0, t, tl, d, ph);
  endtask

  task automatic do_reset();
    step(1'b1, '0, '0, 2'd0, GRN);
    step(1'b1, '0, '0, 2'd0, GRN);
  endtask

  task automatic rot_dir(input logic [1:0] d);
    run('0, '0, d, GRN, MG);
    run('0, '0, d, YEL, YC);
    run('0, '0, d, LG,  MG);
    run('0, '0, d, LY,  YC);
  endtask

  // Monitor: pops one expected state per cycle while the scoreboard holds entries.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus4.dir !== e.d || bus4.phase !== e.ph ||
            bus4.L !== lamp(e.d, e.ph, 1'b0) || bus4.LL !== lamp(e.d, e.ph, 1'b1)) begin
          n_bad++;
          $display("FAIL state4 @%0t: got dir=%0d phase=%b L=%b LL=%b, want dir=%0d phase=%b L=%b LL=%b",
                   $time, bus4.dir, bus4.phase, bus4.L, bus4.LL,
                   e.d, e.ph, lamp(e.d, e.ph, 1'b0), lamp(e.d, e.ph, 1'b1));
        end
      end
    end
  end

  task automatic seq4();
    // Full idle rotation: back to dir0 GRN after 40 cycles.
    do_reset();
    run('0, '0, 2'd0, GRN, MG - 1);
    run('0, '0, 2'd0, YEL, YC);
    run('0, '0, 2'd0, LG,  MG);
    run('0, '0, 2'd0, LY,  YC);
    rot_dir(2'd1);
    rot_dir(2'd2);
    rot_dir(2'd3);
    run('0, '0, 2'd0, GRN, 1);

    // T[0] held high for 20 cycles.
    do_reset();
`ifdef TL_MAX_GREEN_EN
    run(4'b0001, '0, 2'd0, GRN, MXG - 1);
    run(4'b0001, '0, 2'd0, YEL, YC);
    run(4'b0001, '0, 2'd0, LG,  MG);
    run(4'b0001, '0, 2'd0, LY,  YC);
    run(4'b0001, '0, 2'd1, GRN, MG);
    run(4'b0001, '0, 2'd1, YEL, YC);
    run(4'b0001, '0, 2'd1, LG,  1);
    run('0,      '0, 2'd1, LG,  2);
    run('0,      '0, 2'd1, LY,  1);
`else
    run(4'b0001, '0, 2'd0, GRN, 20);
    run('0,      '0, 2'd0, YEL, YC);
    run('0,      '0, 2'd0, LG,  1);
`endif

    // TL[1] extends dir1 LGRN to 5 cycles, then reset during dir2 LYEL.
    do_reset();
    run('0, '0, 2'd0, GRN, MG - 1);
    run('0, '0, 2'd0, YEL, YC);
    run('0, '0, 2'd0, LG,  MG);
    run('0, '0, 2'd0, LY,  YC);
    run('0, '0, 2'd1, GRN, MG);
    run('0, '0, 2'd1, YEL, YC);
    run('0, 4'b0010, 2'd1, LG, 5);
    run('0, '0, 2'd1, LY,  YC);
    run('0, '0, 2'd2, GRN, MG);
    run('0, '0, 2'd2, YEL, YC);
    run('0, '0, 2'd2, LG,  MG);
    run('0, '0, 2'd2, LY,  1);
    step(1'b1, '0, '0, 2'd0, GRN);
    run('0, '0, 2'd0, GRN, MG - 1);
    run('0, '0, 2'd0, YEL, 1);
  endtask

  task automatic seq3();
    logic [1:0] prev;
    int         nonred;
    bit         bad11;
    int         wraps;
    wraps     = 0;
    reset3    = 1'b1;
    bus3.T    = '0;
    bus3.TL   = '0;
    repeat (2) @(negedge clk);
    reset3 = 1'b0;
    prev   = 2'd0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      bus3.T  = 3'($urandom);
      bus3.TL = 3'($urandom);
      @(posedge clk);
      #1;
      nonred = 0;
      bad11  = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (bus3.L[2*k +: 2] != 2'b00)  nonred++;
        if (bus3.LL[2*k +: 2] != 2'b00) nonred++;
        if (bus3.L[2*k +: 2] == 2'b11 || bus3.LL[2*k +: 2] == 2'b11) bad11 = 1'b1;
      end
      n_cmp++;
      if (nonred != 1 || bad11 || bus3.dir > 2'd2) begin
        n_bad++;
        $display("FAIL invariant3 cycle %0d: got nonred=%0d code11=%0b dir=%0d, want 1 0 <=2",
                 i, nonred, bad11, bus3.dir);
      end
      if (bus3.dir != prev) begin
        n_cmp++;
        if (bus3.dir != ((prev == 2'd2) ? 2'd0 : prev + 2'd1) || bus3.phase != GRN) begin
          n_bad++;
          $display("FAIL advance3 cycle %0d: got dir=%0d phase=%b after dir=%0d, want dir=%0d phase=00",
                   i, bus3.dir, bus3.phase, prev, (prev == 2'd2) ? 0 : prev + 1);
        end
        if (prev == 2'd2) wraps++;
        prev = bus3.dir;
      end
    end
    n_cmp++;
    if (wraps == 0) begin
      n_bad++;
      $display("FAIL wrap3: got %0d wraps from dir2 to dir0, want at least 1", wraps);
    end
  endtask

  initial begin
    bus4.T  = '0;
    bus4.TL = '0;
    fork
      seq4();
      seq3();
    join
    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tl_cntr_multi.md
# tl_cntr_multi

Parametrised multi-approach traffic-light controller with protected left-turn phases. It is the next generation of the two-road, left-turn controller. It serves `NUM_DIR` approaches in round-robin order, each with a straight phase and a left phase. Phase lengths come from sensor inputs plus cycle timers for minimum green and fixed yellow. It sits between the per-approach vehicle sensors and the lamp drivers.

## Interface
- `NUM_DIR`, 2 — number of approaches, legal range 2..8.
- `MIN_GREEN`, 3 — minimum cycles in any green state, ≥1.
- `YELLOW_CYCLES`, 2 — exact cycles in any yellow state, ≥1.
- `MAX_GREEN`, 8 — forced-exit cycle count for green states when `TL_MAX_GREEN_EN` is defined; must be ≥ `MIN_GREEN`.
- `clk` in 1 — single clock; everything updates on the rising edge.
- `reset` in 1 — synchronous, active-high reset.
- `T` in `NUM_DIR` — straight-traffic present, bit i is approach i.
- `TL` in `NUM_DIR` — left-turn traffic present, bit i is approach i.
- `L` out `2*NUM_DIR` — straight lamps, bits [2i+1:2i] for approach i.
- `LL` out `2*NUM_DIR` — left lamps, same packing.
- `dir` out `$clog2(NUM_DIR)` — approach currently served.
- `phase` out 2 — current phase: 00 GRN, 01 YEL, 10 LGRN, 11 LYEL.

## Operation
- Lamp code: 00 red, 01 green, 10 yellow. Code 11 is never driven.
- The state is the pair (`dir`, `phase`). A cycle timer `cnt` is sized to hold max(`MIN_GREEN`, `YELLOW_CYCLES`, `MAX_GREEN`) − 1.
- `cnt` clears to 0 on every state change and otherwise increments, saturating.
- Phase sequence per approach: GRN → YEL → LGRN → LYEL. After LYEL, `dir` advances to (`dir`+1) mod `NUM_DIR` and the phase becomes GRN. The wrap from `NUM_DIR`−1 to 0 is explicit, including for non-power-of-2 `NUM_DIR`.
- Leaving GRN: when `cnt` ≥ `MIN_GREEN`−1 and `T[dir]`==0.
- Leaving LGRN: when `cnt` ≥ `MIN_GREEN`−1 and `TL[dir]`==0.
- Leaving YEL or LYEL: when `cnt` == `YELLOW_CYCLES`−1, independent of sensors.
- Sensors are sampled only for the approach in `dir`. Other bits are ignored and no requests are latched. Each approach gets its left phase every rotation, even with `TL` low; that phase lasts `MIN_GREEN` cycles.
- Lamps are a Moore decode of state. Approach `dir` shows:
  - GRN: `L`=01, `LL`=00.
  - YEL: `L`=10, `LL`=00.
  - LGRN: `L`=00, `LL`=01.
  - LYEL: `L`=00, `LL`=10.
- All other approaches show 00 on both lamps.
- Safety invariant: at most one lamp field in `L`/`LL` is non-red in any cycle.

## Timing
- Reset values: `dir`=0, `phase`=GRN, `cnt`=0. `L` has approach 0 = 01 and all others 00; `LL` is all 00.
- Reset dominates every other input on the same edge. Reset asserted mid-phase, including during a yellow, returns the block to the reset state on the next edge with no yellow clean-up.
- Sensor-to-state latency: a `T`/`TL` value sampled at edge k decides the state at edge k; the new lamps are visible after that edge. No input registering.
- Minimum dwell with all sensors low: GRN=`MIN_GREEN`, YEL=`YELLOW_CYCLES`, LGRN=`MIN_GREEN`, LYEL=`YELLOW_CYCLES` cycles.
- Minimum rotation with all sensors low: `NUM_DIR`·2·(`MIN_GREEN`+`YELLOW_CYCLES`) cycles.
- A sensor dropping and re-rising while `cnt` < `MIN_GREEN`−1 has no effect. Only its value at or after the minimum matters.

## Configuration
- `TL_MAX_GREEN_EN` defined: GRN and LGRN also exit when `cnt` == `MAX_GREEN`−1, regardless of `T`/`TL`. This bounds the full rotation time.
- `TL_MAX_GREEN_EN` undefined: green states hold for as long as their sensor is high. `MAX_GREEN` is unused, and no logic for it may be synthesised.

## Test plan
- Reset, then hold `T`=`TL`=0 with `NUM_DIR`=4, `MIN_GREEN`=3, `YELLOW_CYCLES`=2. The state walks dir0 GRN(3) YEL(2) LGRN(3) LYEL(2), then dir1 … dir3, and returns to dir0 GRN after exactly 40 cycles. Lamps match the decode every cycle.
- `T[0]`=1 for 20 cycles, macro undefined. dir0 stays in GRN for all 20 cycles. YEL starts on the first edge after `T[0]` falls.
- Same stimulus with `TL_MAX_GREEN_EN` and `MAX_GREEN`=8. GRN lasts exactly 8 cycles, then YEL, even though `T[0]` stays 1.
- `TL[1]`=1 for 5 cycles from LGRN entry, then 0. dir1 LGRN lasts 5 cycles, with `LL`[3:2]=01 throughout and all `L` bits 00.
- Assert `reset` for 1 cycle during dir2 LYEL. The next cycle shows `dir`=0, GRN, `L`=…0001, `LL`=0, and the rotation restarts with full `MIN_GREEN`.
- `NUM_DIR`=3: the rotation wraps from dir2 to dir0, never dir3. A checker confirms the one-non-red-lamp invariant over 1000 cycles of random `T`/`TL`.
